// File: rtl/shift_right_seq_32.sv
// -----------------------------------------------------------------------------
// shift_right_seq_32
//
// Sequential right shifter: one bit per clock. A request accepted in IDLE or
// DONE loads the operand into the result register, the shift amount into a
// down-counter and the fill policy into a flag. The block then spends exactly
// shamt cycles in SHIFT and flags completion with a one-cycle done pulse, so
// the latency is always shamt+1 edges from the accepting edge.
//
// Ports
//   clk     in   1       rising-edge clock for all state
//   reset   in   1       asynchronous, active-high reset
//   start   in   1       request a new shift (ignored while busy)
//   value   in   WIDTH   operand, sampled on the accepting edge
//   shamt   in   log2(W) shift amount, sampled on the accepting edge
//   arith   in   1       1 = arithmetic (sign fill), 0 = logical (zero fill)
//   busy    out  1       high while in SHIFT
//   done    out  1       one-cycle pulse, result valid
//   result  out  WIDTH   registered shift result, held until next accept
// -----------------------------------------------------------------------------
module shift_right_seq_32 #(
  parameter int WIDTH = 32,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic [SW-1:0]    shamt,
  input  logic             arith,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SW-1:0] CNT_ZERO = SW'(0);
  localparam logic [SW-1:0] CNT_ONE  = SW'(1);

  state_t           state_q;
  logic [WIDTH-1:0] result_q;
  logic [SW-1:0]    cnt_q;
  logic             fill_q;
  logic             busy_q;
  logic             done_q;

  logic             fill_bit_s;
  logic [WIDTH-1:0] shifted_d;

  // One-bit right shift of the working register using the latched fill policy
  always_comb begin
    fill_bit_s = 1'b0;
    if (fill_q) begin
      fill_bit_s = result_q[WIDTH-1];
    end else begin
      fill_bit_s = 1'b0;
    end
    shifted_d = {fill_bit_s, result_q[WIDTH-1:1]};
  end

  // Control FSM, operand registers and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= {WIDTH{1'b0}};
      cnt_q    <= CNT_ZERO;
      fill_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            result_q <= value;
            cnt_q    <= shamt;
            fill_q   <= arith;
            // A zero shift has nothing to do; go straight to DONE so the
            // latency stays at shamt+1 edges.
            if (shamt == CNT_ZERO) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= SHIFT;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        SHIFT: begin
          // start is deliberately not looked at here: operands are frozen.
          result_q <= shifted_d;
          cnt_q    <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          result_q <= {WIDTH{1'b0}};
          cnt_q    <= CNT_ZERO;
          fill_q   <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_shift_right_seq_32.sv
// -----------------------------------------------------------------------------
// tb_shift_right_seq_32
//
// Self-checking bench. A transaction-level model tracks the last accepted
// request and the number of edges since it was accepted; from that it derives
// busy, done and the partially shifted result with plain >> / >>> arithmetic.
// Outputs are compared against the model on every falling edge. Directed
// scenarios add literal expectations for results and latencies.
// -----------------------------------------------------------------------------
module tb_shift_right_seq_32;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] value;
  logic [4:0]  shamt;
  logic        arith;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  shift_right_seq_32 #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .value  (value),
    .shamt  (shamt),
    .arith  (arith),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  bit          m_act = 1'b0;   // a request has been accepted since reset
  int          m_k   = 0;      // edges since (and including) the accepting edge
  logic [31:0] m_v   = 32'h0;
  int          m_s   = 0;
  bit          m_a   = 1'b0;

  function automatic logic [31:0] shr(input logic [31:0] v, input int n, input bit a);
    logic signed [31:0] sv;
    sv = v;
    if (a) return 32'(sv >>> n);
    else   return v >> n;
  endfunction

  function automatic bit m_busy();
    return m_act && (m_k >= 1) && (m_k <= m_s);
  endfunction

  function automatic bit m_done();
    return m_act && (m_k == m_s + 1);
  endfunction

  function automatic logic [31:0] m_result();
    int n;
    if (!m_act) return 32'h0;
    n = (m_k - 1 < m_s) ? (m_k - 1) : m_s;
    return shr(m_v, n, m_a);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act = 1'b0;
      m_k   = 0;
    end else begin
      if (start && !m_busy()) begin
        m_act = 1'b1;
        m_k   = 1;
        m_v   = value;
        m_s   = int'(shamt);
        m_a   = arith;
      end else if (m_act && m_k < 1000) begin
        m_k = m_k + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("busy",   {31'b0, busy}, {31'b0, m_busy()});
    chk("done",   {31'b0, done}, {31'b0, m_done()});
    chk("result", result, m_result());
  end

  // ---------------- directed helpers ----------------
  // Pulse start for one edge (optionally re-pulsing with value=0 while busy),
  // then count edges until done and compare latency and result to literals.
  task automatic do_op(input logic [31:0] v, input logic [4:0] s, input bit a,
                       input bit repulse, input logic [31:0] exp_res, input int exp_edges,
                       input string name);
    int n;
    int busy_cycles;
    start = 1'b1; value = v; shamt = s; arith = a;
    @(posedge clk); #1;
    n = 1;
    busy_cycles = 0;
    start = 1'b0;
    while (!done && n < 100) begin
      if (busy) busy_cycles++;
      if (repulse) begin
        start = n[0];
        value = 32'h0;
        shamt = 5'd3;
        arith = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk({name, "_edges"}, n, exp_edges);
    chk({name, "_busy_cycles"}, busy_cycles, exp_edges - 1);
    chk({name, "_result"}, result, exp_res);
    @(posedge clk); #1;
    chk({name, "_done_clears"}, {31'b0, done}, 32'h0);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; value = 32'h0; shamt = 5'd0; arith = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   {31'b0, busy}, 32'h0);
    chk("rst_done",   {31'b0, done}, 32'h0);
    chk("rst_result", result, 32'h0);
    reset = 1'b0;

    // First edge after reset release accepts start
    do_op(32'h80000000, 5'd4,  1'b0, 1'b0, 32'h08000000, 5,  "srl4");
    do_op(32'h80000000, 5'd4,  1'b1, 1'b0, 32'hF8000000, 5,  "sra4");
    do_op(32'h12345678, 5'd0,  1'b0, 1'b0, 32'h12345678, 1,  "sh0");
    do_op(32'h80000000, 5'd31, 1'b1, 1'b1, 32'hFFFFFFFF, 32, "sra31_repulse");
    do_op(32'h80000000, 5'd31, 1'b0, 1'b0, 32'h00000001, 32, "srl31");
    do_op(32'h7FFFFFFF, 5'd31, 1'b1, 1'b0, 32'h00000000, 32, "sra31_pos");

    // Reset mid-SHIFT aborts immediately
    start = 1'b1; value = 32'hDEADBEEF; shamt = 5'd8; arith = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_abort_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    chk("abort_busy",   {31'b0, busy}, 32'h0);
    chk("abort_done",   {31'b0, done}, 32'h0);
    chk("abort_result", result, 32'h0);
    @(negedge clk); #1;
    reset = 1'b0;
    n = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    chk("abort_no_done", n, 0);
    do_op(32'h000000F0, 5'd4, 1'b0, 1'b0, 32'h0000000F, 5, "after_abort");

    // Back-to-back: start held high through DONE with new operands
    start = 1'b1; value = 32'h80000000; shamt = 5'd4; arith = 1'b0;
    @(posedge clk); #1;
    value = 32'hFFFF0000; shamt = 5'd16; arith = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_first_edges",  n, 5);
    chk("b2b_first_result", result, 32'h08000000);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accept_busy", {31'b0, busy}, 32'h1);
    n = 1;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_second_edges",  n, 17);
    chk("b2b_second_result", result, 32'h0000FFFF);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      value = $urandom;
      case ($urandom_range(0, 3))
        0:       shamt = 5'd0;
        1:       shamt = 5'd31;
        default: shamt = 5'($urandom_range(0, 31));
      endcase
      arith = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
